// File: rtl/upd1771_pkg.sv
// upd1771_pkg: shared types, widths, command codes and the tone waveform ROM
// contents for the uPD1771 tone voice.
package upd1771_pkg;

  localparam int TIMBRE_W = 3;
  localparam int PHASE_W  = 5;
  localparam int VOL_W    = 5;
  localparam int PERIOD_W = 8;

  localparam logic [7:0] CMD_SILENCE = 8'h00;
  localparam logic [7:0] CMD_NOISE   = 8'h01;
  localparam logic [7:0] CMD_TONE    = 8'h02;
  localparam logic [7:0] CMD_PCM     = 8'h1f;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} tone_state_e;

  typedef struct packed {
    logic [TIMBRE_W-1:0] timbre;
    logic [PHASE_W-1:0]  offset;
    logic [PERIOD_W-1:0] period;
    logic [VOL_W-1:0]    volume;
  } tone_params_t;

  // 8 timbres x 32 phases, signed 8-bit.
  //   0 rising saw, 1 square, 2 triangle, 3 25% pulse, 4 12.5% pulse,
  //   5 falling saw, 6 sine, 7 half-wave sine
  localparam logic signed [7:0] WAVE_TABLE [8][32] = '{
    '{ 8'sh80, -8'sd120, -8'sd112, -8'sd104, -8'sd96, -8'sd88, -8'sd80, -8'sd72,
      -8'sd64, -8'sd56, -8'sd48, -8'sd40, -8'sd32, -8'sd24, -8'sd16, -8'sd8,
       8'sd0,  8'sd8,  8'sd16, 8'sd24, 8'sd32, 8'sd40, 8'sd48, 8'sd56,
       8'sd64, 8'sd72, 8'sd80, 8'sd88, 8'sd96, 8'sd104, 8'sd112, 8'sd120 },
    '{ 8'sd127, 8'sd127, 8'sd127, 8'sd127, 8'sd127, 8'sd127, 8'sd127, 8'sd127,
       8'sd127, 8'sd127, 8'sd127, 8'sd127, 8'sd127, 8'sd127, 8'sd127, 8'sd127,
       8'sh80, 8'sh80, 8'sh80, 8'sh80, 8'sh80, 8'sh80, 8'sh80, 8'sh80,
       8'sh80, 8'sh80, 8'sh80, 8'sh80, 8'sh80, 8'sh80, 8'sh80, 8'sh80 },
    '{ 8'sh80, -8'sd112, -8'sd96, -8'sd80, -8'sd64, -8'sd48, -8'sd32, -8'sd16,
       8'sd0,  8'sd16, 8'sd32, 8'sd48, 8'sd64, 8'sd80, 8'sd96, 8'sd112,
       8'sd127, 8'sd111, 8'sd95, 8'sd79, 8'sd63, 8'sd47, 8'sd31, 8'sd15,
      -8'sd1, -8'sd17, -8'sd33, -8'sd49, -8'sd65, -8'sd81, -8'sd97, -8'sd113 },
    '{ 8'sd127, 8'sd127, 8'sd127, 8'sd127, 8'sd127, 8'sd127, 8'sd127, 8'sd127,
       8'sh80, 8'sh80, 8'sh80, 8'sh80, 8'sh80, 8'sh80, 8'sh80, 8'sh80,
       8'sh80, 8'sh80, 8'sh80, 8'sh80, 8'sh80, 8'sh80, 8'sh80, 8'sh80,
       8'sh80, 8'sh80, 8'sh80, 8'sh80, 8'sh80, 8'sh80, 8'sh80, 8'sh80 },
    '{ 8'sd127, 8'sd127, 8'sd127, 8'sd127, 8'sh80, 8'sh80, 8'sh80, 8'sh80,
       8'sh80, 8'sh80, 8'sh80, 8'sh80, 8'sh80, 8'sh80, 8'sh80, 8'sh80,
       8'sh80, 8'sh80, 8'sh80, 8'sh80, 8'sh80, 8'sh80, 8'sh80, 8'sh80,
       8'sh80, 8'sh80, 8'sh80, 8'sh80, 8'sh80, 8'sh80, 8'sh80, 8'sh80 },
    '{ 8'sd120, 8'sd112, 8'sd104, 8'sd96, 8'sd88, 8'sd80, 8'sd72, 8'sd64,
       8'sd56, 8'sd48, 8'sd40, 8'sd32, 8'sd24, 8'sd16, 8'sd8, 8'sd0,
      -8'sd8, -8'sd16, -8'sd24, -8'sd32, -8'sd40, -8'sd48, -8'sd56, -8'sd64,
      -8'sd72, -8'sd80, -8'sd88, -8'sd96, -8'sd104, -8'sd112, -8'sd120, 8'sh80 },
    '{ 8'sd0, 8'sd25, 8'sd49, 8'sd71, 8'sd90, 8'sd106, 8'sd117, 8'sd125,
       8'sd127, 8'sd125, 8'sd117, 8'sd106, 8'sd90, 8'sd71, 8'sd49, 8'sd25,
       8'sd0, -8'sd25, -8'sd49, -8'sd71, -8'sd90, -8'sd106, -8'sd117, -8'sd125,
      -8'sd127, -8'sd125, -8'sd117, -8'sd106, -8'sd90, -8'sd71, -8'sd49, -8'sd25 },
    '{ 8'sd0, 8'sd25, 8'sd49, 8'sd71, 8'sd90, 8'sd106, 8'sd117, 8'sd125,
       8'sd127, 8'sd125, 8'sd117, 8'sd106, 8'sd90, 8'sd71, 8'sd49, 8'sd25,
       8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0,
       8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0 }
  };

endpackage

// File: rtl/upd1771_wave_rom.sv
// upd1771_wave_rom: registered waveform lookup, one CLK of latency.
// No reset on the data register so it can map onto block ROM; the consumer
// gates stale contents with its own valid bit.
module upd1771_wave_rom
  import upd1771_pkg::*;
(
  input  logic                CLK,
  input  logic [TIMBRE_W-1:0] timbre,
  input  logic [PHASE_W-1:0]  phase,
  output logic signed [7:0]   data
);

  logic signed [7:0] data_d;
  logic signed [7:0] data_q;

  // table lookup
  always_comb data_d = WAVE_TABLE[timbre][phase];

  // synchronous read register
  always_ff @(posedge CLK) data_q <= data_d;

  assign data = data_q;

endmodule

// File: rtl/upd1771_tone.sv
// upd1771_tone: uPD1771 tone voice. Latches a decoded TONE packet, steps a
// 32-entry waveform every PRESCALE*PERIOD CE ticks, and scales the waveform
// by VOLUME into a signed PCM sample (2 CLK from phase to SAMPLE).
// Optional feature macro: UPD1771_TONE_OFFSET_LOOP_EN -- when defined the
// phase wraps 31 -> latched OFFSET instead of 31 -> 0.
module upd1771_tone
  import upd1771_pkg::*;
#(
  parameter int PRESCALE = 32,
  parameter int OUT_W    = 16
) (
  input  logic                    CLK,
  input  logic                    RESB,
  input  logic                    CE,
  input  logic                    LD,
  input  logic                    STOP,
  input  logic [TIMBRE_W-1:0]     TIMBRE,
  input  logic [PHASE_W-1:0]      OFFSET,
  input  logic [PERIOD_W-1:0]     PERIOD,
  input  logic [VOL_W-1:0]        VOLUME,
  output logic signed [OUT_W-1:0] SAMPLE,
  output logic                    ACTIVE
);

  localparam logic [7:0]         PRESC_LAST = 8'(PRESCALE - 1);
  localparam logic [PHASE_W-1:0] PHASE_LAST = '1;

`ifdef UPD1771_TONE_OFFSET_LOOP_EN
  localparam logic LOOP_EN = 1'b1;
`else
  localparam logic LOOP_EN = 1'b0;
`endif

  tone_state_e         state_q, state_d;
  tone_params_t        prm_q, prm_d;
  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic [7:0]          presc_q, presc_d;
  logic [PERIOD_W-1:0] pcnt_q, pcnt_d;
  logic                active_q, active_d;

  logic                vld_q, vld_d;
  logic signed [OUT_W-1:0] sample_q, sample_d;

  logic [PHASE_W-1:0]  wrap_phase;
  logic                kill;
  logic signed [7:0]   rom_data;
  logic signed [13:0]  mul_a, mul_b, prod14;
  logic signed [12:0]  prod13;

  // loop-back target when the phase passes entry 31
  assign wrap_phase = prm_q.offset & {PHASE_W{LOOP_EN}};

  // any LD or STOP flushes the output pipeline so old data never leaks out
  assign kill = LD | STOP;

  // control next-state: packet load, stop, and CE-paced phase stepping
  always_comb begin
    state_d  = state_q;
    prm_d    = prm_q;
    phase_d  = phase_q;
    presc_d  = presc_q;
    pcnt_d   = pcnt_q;
    active_d = active_q;
    if (LD) begin
      prm_d   = '{timbre: TIMBRE, offset: OFFSET, period: PERIOD, volume: VOLUME};
      phase_d = OFFSET;
      presc_d = '0;
      pcnt_d  = PERIOD;
      if (PERIOD != '0) begin
        state_d  = S_RUN;
        active_d = 1'b1;
      end else begin
        // a zero period is a silent packet
        state_d  = S_IDLE;
        active_d = 1'b0;
      end
    end else if (STOP) begin
      state_d  = S_IDLE;
      active_d = 1'b0;
    end else if (state_q == S_RUN && CE) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        if (pcnt_q == PERIOD_W'(1)) begin
          pcnt_d  = prm_q.period;
          phase_d = (phase_q == PHASE_LAST) ? wrap_phase : phase_q + 1'b1;
        end else begin
          pcnt_d = pcnt_q - 1'b1;
        end
      end else begin
        presc_d = presc_q + 8'd1;
      end
    end
  end

  // control state registers (FSM, parameters, counters)
  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      state_q  <= S_IDLE;
      prm_q    <= '0;
      phase_q  <= '0;
      presc_q  <= '0;
      pcnt_q   <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      prm_q    <= prm_d;
      phase_q  <= phase_d;
      presc_q  <= presc_d;
      pcnt_q   <= pcnt_d;
      active_q <= active_d;
    end
  end

  // stage 1: waveform lookup for the current phase
  upd1771_wave_rom u_rom (
    .CLK    (CLK),
    .timbre (prm_q.timbre),
    .phase  (phase_q),
    .data   (rom_data)
  );

  // stage 2 inputs: signed wave x unsigned volume, 13-bit product
  always_comb begin
    mul_a  = 14'(rom_data);
    mul_b  = 14'($signed({1'b0, prm_q.volume}));
    prod14 = mul_a * mul_b;
    prod13 = prod14[12:0];
    vld_d  = ~kill & (state_q == S_RUN);
    sample_d = (kill | ~vld_q) ? '0 : OUT_W'(prod13);
  end

  // output pipeline: valid alongside the ROM stage, then the scaled sample
  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      vld_q    <= 1'b0;
      sample_q <= '0;
    end else begin
      vld_q    <= vld_d;
      sample_q <= sample_d;
    end
  end

  assign SAMPLE = sample_q;
  assign ACTIVE = active_q;

endmodule

// File: tb/tb_upd1771_tone.sv
// tb_upd1771_tone: directed checks of the uPD1771 tone voice with PRESCALE=4.
// Expected samples come from the hand-written waveform values below
// (timbre 0 is a rising saw: entry n = -128 + 8*n).
module tb_upd1771_tone;

  logic              CLK = 1'b0;
  logic              RESB;
  logic              CE;
  logic              LD;
  logic              STOP;
  logic [2:0]        TIMBRE;
  logic [4:0]        OFFSET;
  logic [7:0]        PERIOD;
  logic [4:0]        VOLUME;
  logic signed [15:0] SAMPLE;
  logic              ACTIVE;

  int n_tests = 0;
  int n_fail  = 0;

  upd1771_tone #(.PRESCALE(4), .OUT_W(16)) dut (
    .CLK    (CLK),
    .RESB   (RESB),
    .CE     (CE),
    .LD     (LD),
    .STOP   (STOP),
    .TIMBRE (TIMBRE),
    .OFFSET (OFFSET),
    .PERIOD (PERIOD),
    .VOLUME (VOLUME),
    .SAMPLE (SAMPLE),
    .ACTIVE (ACTIVE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // present a packet for one edge; afterwards we sit at k=0 relative to it
  task automatic load(input logic [2:0] t, input logic [4:0] o,
                      input logic [7:0] p, input logic [4:0] v, input logic stp);
    TIMBRE = t; OFFSET = o; PERIOD = p; VOLUME = v;
    LD = 1'b1; STOP = stp;
    tick(1);
    LD = 1'b0; STOP = 1'b0;
  endtask

  logic signed [31:0] exp_wrap;

  initial begin
    RESB = 1'b1; CE = 1'b0; LD = 1'b0; STOP = 1'b0;
    TIMBRE = '0; OFFSET = '0; PERIOD = '0; VOLUME = '0;
    #2 RESB = 1'b0;
    #1;
    chk("reset_sample", 32'(SAMPLE), 0);
    chk("reset_active", 32'(ACTIVE), 0);
    #10 RESB = 1'b1;
    tick(3);
    chk("idle_sample", 32'(SAMPLE), 0);
    chk("idle_active", 32'(ACTIVE), 0);

    // basic run: T0, O0, P3, V1 -> phase steps every 12 cycles
    CE = 1'b1;
    load(3'd0, 5'd0, 8'd3, 5'd1, 1'b0);
    chk("run_active", 32'(ACTIVE), 1);
    tick(1);
    chk("run_k1_zero", 32'(SAMPLE), 0);
    tick(1);
    chk("run_k2_ph0", 32'(SAMPLE), -128);
    tick(11);
    chk("run_k13_ph0", 32'(SAMPLE), -128);
    tick(1);
    chk("run_k14_ph1", 32'(SAMPLE), -120);
    tick(360);
    chk("run_k374_ph31", 32'(SAMPLE), 120);
    tick(11);
    chk("run_k385_ph31", 32'(SAMPLE), 120);
    tick(1);
    chk("run_k386_wrap0", 32'(SAMPLE), -128);

    // PERIOD=0 while running: silence at once, no stale ROM data
    load(3'd0, 5'd10, 8'd0, 5'd1, 1'b0);
    chk("p0run_active", 32'(ACTIVE), 0);
    chk("p0run_k0", 32'(SAMPLE), 0);
    tick(1);
    chk("p0run_k1", 32'(SAMPLE), 0);
    tick(1);
    chk("p0run_k2", 32'(SAMPLE), 0);

    // PERIOD=0 from IDLE stays silent
    load(3'd0, 5'd0, 8'd0, 5'd1, 1'b0);
    tick(3);
    chk("p0idle_active", 32'(ACTIVE), 0);
    chk("p0idle_sample", 32'(SAMPLE), 0);

    // full-scale negative: -128 * 31 = -3968
    load(3'd0, 5'd0, 8'd3, 5'd31, 1'b0);
    tick(2);
    chk("vol31_neg", 32'(SAMPLE), -3968);
    chk("vol31_neg_hex", 32'($unsigned(SAMPLE)), 32'h0000_f080);

    // STOP + LD together mid-run: restart at new offset with no gap
    load(3'd0, 5'd20, 8'd2, 5'd2, 1'b1);
    chk("restart_active_k0", 32'(ACTIVE), 1);
    tick(1);
    chk("restart_active_k1", 32'(ACTIVE), 1);
    tick(1);
    chk("restart_k2_ph20", 32'(SAMPLE), 64);
    tick(7);
    chk("restart_k9_ph20", 32'(SAMPLE), 64);
    tick(1);
    chk("restart_k10_ph21", 32'(SAMPLE), 80);

    // positive full-scale: 120 * 31 = 3720, then STOP alone
    load(3'd0, 5'd31, 8'd3, 5'd31, 1'b0);
    tick(2);
    chk("vol31_pos", 32'(SAMPLE), 3720);
    STOP = 1'b1;
    tick(1);
    STOP = 1'b0;
    chk("stop_sample_k0", 32'(SAMPLE), 0);
    chk("stop_active_k0", 32'(ACTIVE), 0);
    tick(3);
    chk("stop_sample_k3", 32'(SAMPLE), 0);

    // phase wrap from OFFSET=28, P1: phase steps every 4 cycles
    load(3'd0, 5'd28, 8'd1, 5'd1, 1'b0);
    tick(2);
    chk("wrap_k2_ph28", 32'(SAMPLE), 96);
    tick(12);
    chk("wrap_k14_ph31", 32'(SAMPLE), 120);
`ifdef UPD1771_TONE_OFFSET_LOOP_EN
    exp_wrap = 96;
`else
    exp_wrap = -128;
`endif
    tick(4);
    chk("wrap_k18_next", 32'(SAMPLE), exp_wrap);

    // VOLUME=0: silent but active
    load(3'd6, 5'd8, 8'd1, 5'd0, 1'b0);
    tick(2);
    chk("vol0_sample", 32'(SAMPLE), 0);
    chk("vol0_active", 32'(ACTIVE), 1);
    tick(5);
    chk("vol0_sample_k7", 32'(SAMPLE), 0);

    // other timbres: square at phase 16, sine at phase 8 (V3)
    load(3'd1, 5'd16, 8'd5, 5'd1, 1'b0);
    tick(2);
    chk("square_ph16", 32'(SAMPLE), -128);
    load(3'd6, 5'd8, 8'd5, 5'd3, 1'b0);
    tick(2);
    chk("sine_ph8", 32'(SAMPLE), 381);

    // CE low freezes counters; stepping resumes PRESCALE*PERIOD ticks later
    CE = 1'b0;
    load(3'd0, 5'd0, 8'd1, 5'd1, 1'b0);
    tick(2);
    chk("ce0_k2", 32'(SAMPLE), -128);
    tick(18);
    chk("ce0_k20_hold", 32'(SAMPLE), -128);
    CE = 1'b1;
    tick(5);
    chk("ce1_k25_hold", 32'(SAMPLE), -128);
    tick(1);
    chk("ce1_k26_ph1", 32'(SAMPLE), -120);

    // asynchronous reset between edges while running
    tick(3);
    #2 RESB = 1'b0;
    #1;
    chk("areset_sample", 32'(SAMPLE), 0);
    chk("areset_active", 32'(ACTIVE), 0);
    #4 RESB = 1'b1;
    tick(1);
    chk("post_reset_active", 32'(ACTIVE), 0);
    tick(6);
    chk("post_reset_sample", 32'(SAMPLE), 0);
    chk("post_reset_active2", 32'(ACTIVE), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
